// File: rtl/uart_sample_tx.sv
// 16-bit sample to UART serialiser: two 8N1 bytes per sample, LSB byte first, DELAY_FRAMES clocks per bit.
// Define UART_SAMPLE_TX_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise the buffer is a single holding slot.
module uart_sample_tx #(
    parameter int DELAY_FRAMES = 15,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [12:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic        phase, phase_n;  // 0: LSB byte, 1: MSB byte
    logic [15:0] hold, hold_n;
    logic [7:0]  byte_n;
    logic        last, tx_n;
    logic        push, pop, buf_empty;
    logic [15:0] buf_head;

    assign push = sample_valid && sample_ready;

`ifdef UART_SAMPLE_TX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    assign sample_ready = (count != LW'(FIFO_DEPTH));
    assign buf_empty    = (count == '0);
    assign buf_head     = mem[rd_ptr];
    assign fifo_level   = count;
`else
    logic        full;
    logic [15:0] slot;

    // Push needs the slot empty and pop needs it full, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       full <= 1'b0;
        else if (push) full <= 1'b1;
        else if (pop)  full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) slot <= sample_in;
    end

    assign sample_ready = !full;
    assign buf_empty    = !full;
    assign buf_head     = slot;
    assign fifo_level   = LW'(full);
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        phase_n = phase;
        hold_n  = hold;
        pop     = 1'b0;
        last    = (cnt == 13'(DELAY_FRAMES - 1));
        case (state)
            IDLE: begin
                if (!buf_empty) begin
                    pop     = 1'b1;
                    hold_n  = buf_head;
                    phase_n = 1'b0;
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (last) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 13'd1;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_n = '0;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    cnt_n = cnt + 13'd1;
                end
            end
            STOP: begin
                if (last) begin
                    cnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                        state_n = START;
                    end else if (!buf_empty) begin
                        // Chain straight into the next sample with no idle bit.
                        pop     = 1'b1;
                        hold_n  = buf_head;
                        phase_n = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 13'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is computed from the next state so uart_tx can be a plain register.
        byte_n = phase_n ? hold_n[15:8] : hold_n[7:0];
        tx_n   = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = byte_n[idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            phase   <= 1'b0;
            hold    <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            phase   <= phase_n;
            hold    <= hold_n;
            uart_tx <= tx_n;
        end
    end

    assign busy = (state != IDLE);

endmodule
